// File: rtl/alu_datapath.sv
// Falling-edge accumulator datapath: operand A, ALU result R and committed accumulator C, each gated by its own strobe.
// Optional macro ALU_SAT_EN saturates ADD/SUB results on signed overflow; undefined, results wrap.
module alu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic             enA,
  input  logic             enALU,
  input  logic             enC,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       op,
  input  logic             bsel,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] C_out,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf,
  output logic             ovf_sticky,
  output logic             res_vld
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_PASS = 3'b101,
    OP_SHL  = 3'b110,
    OP_NOT  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] c_q, c_d;
  flags_t           rflg_q, rflg_d;
  flags_t           cflg_q, cflg_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             res_vld_q, res_vld_d;

  alu_op_e          op_e;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] raw_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  // B comes from the accumulator value held before this edge, so feedback never races the commit.
  assign op_e     = alu_op_e'(op);
  assign alu_b    = bsel ? din : c_q;
  assign sum_ext  = {1'b0, a_q} + {1'b0, alu_b};
  assign diff_ext = {1'b0, a_q} - {1'b0, alu_b};
  assign add_ovf  = (a_q[MSB] == alu_b[MSB]) && (sum_ext[MSB] != a_q[MSB]);
  assign sub_ovf  = (a_q[MSB] != alu_b[MSB]) && (diff_ext[MSB] != a_q[MSB]);

  always_comb begin
    raw_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_e)
      OP_ADD: begin
        raw_res = sum_ext[MSB:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = add_ovf;
      end
      OP_SUB: begin
        raw_res = diff_ext[MSB:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = sub_ovf;
      end
      OP_AND:  raw_res = a_q & alu_b;
      OP_OR:   raw_res = a_q | alu_b;
      OP_XOR:  raw_res = a_q ^ alu_b;
      OP_PASS: raw_res = a_q;
      OP_SHL: begin
        raw_res = {a_q[MSB-1:0], 1'b0};
        alu_c   = a_q[MSB];
      end
      OP_NOT:  raw_res = ~a_q;
      default: raw_res = '0;
    endcase
  end

`ifdef ALU_SAT_EN
  logic [WIDTH-1:0] sat_max;
  logic [WIDTH-1:0] sat_min;

  // Only ADD/SUB raise alu_v; for both, the overflow direction follows the sign of A.
  assign sat_max = {1'b0, {MSB{1'b1}}};
  assign sat_min = {1'b1, {MSB{1'b0}}};
  assign alu_res = alu_v ? (a_q[MSB] ? sat_min : sat_max) : raw_res;
`else
  assign alu_res = raw_res;
`endif

  always_comb begin
    a_d    = enA ? din : a_q;
    r_d    = r_q;
    rflg_d = rflg_q;
    if (enALU) begin
      r_d      = alu_res;
      rflg_d.z = (alu_res == '0);
      rflg_d.n = alu_res[MSB];
      rflg_d.c = alu_c;
      rflg_d.v = alu_v;
    end
    c_d    = enC ? r_q : c_q;
    cflg_d = enC ? rflg_q : cflg_q;
    // A committed overflow outranks a clear request on the same edge.
    if (enC && rflg_q.v) begin
      ovf_sticky_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky_d = 1'b0;
    end else begin
      ovf_sticky_d = ovf_sticky_q;
    end
    res_vld_d = enC;
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      a_q          <= '0;
      r_q          <= '0;
      rflg_q       <= '0;
      c_q          <= '0;
      cflg_q       <= '0;
      ovf_sticky_q <= 1'b0;
      res_vld_q    <= 1'b0;
    end else begin
      a_q          <= a_d;
      r_q          <= r_d;
      rflg_q       <= rflg_d;
      c_q          <= c_d;
      cflg_q       <= cflg_d;
      ovf_sticky_q <= ovf_sticky_d;
      res_vld_q    <= res_vld_d;
    end
  end

  assign C_out      = c_q;
  assign zf         = cflg_q.z;
  assign nf         = cflg_q.n;
  assign cf         = cflg_q.c;
  assign vf         = cflg_q.v;
  assign ovf_sticky = ovf_sticky_q;
  assign res_vld    = res_vld_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed vector table, randomized traffic against a reference model, and reset corners.
// Honours ALU_SAT_EN the same way the design does.
module tb_alu_datapath;

  logic       CLKb = 1'b1;
  logic       RSTb = 1'b1;
  logic       enA = 1'b0;
  logic       enALU = 1'b0;
  logic       enC = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] op = 3'b000;
  logic       bsel = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] C_out;
  logic       zf;
  logic       nf;
  logic       cf;
  logic       vf;
  logic       ovf_sticky;
  logic       res_vld;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers; flags kept as {z, n, c, v}
  int     m_a;
  int     m_r;
  int     m_c;
  bit [3:0] m_rf;
  bit [3:0] m_cf;
  bit     m_st;
  bit     m_vld;

`ifdef ALU_SAT_EN
  localparam logic [7:0] OV1_C = 8'h7F;
  localparam bit         OV1_N = 1'b0;
  localparam logic [7:0] OV2_C = 8'h7F;
  localparam bit         OV2_N = 1'b0;
`else
  localparam logic [7:0] OV1_C = 8'h90;
  localparam bit         OV1_N = 1'b1;
  localparam logic [7:0] OV2_C = 8'h80;
  localparam bit         OV2_N = 1'b1;
`endif

  typedef struct {
    bit         en_a;
    bit         en_alu;
    bit         en_c;
    logic [7:0] d;
    logic [2:0] o;
    bit         b;
    bit         clr;
    logic [7:0] exp_c;
    bit         exp_z;
    bit         exp_n;
    bit         exp_cy;
    bit         exp_v;
    bit         exp_st;
    bit         exp_vld;
  } vec_t;

  vec_t tbl[$];

  alu_datapath #(.WIDTH(8)) dut (
    .CLKb(CLKb),
    .RSTb(RSTb),
    .enA(enA),
    .enALU(enALU),
    .enC(enC),
    .din(din),
    .op(op),
    .bsel(bsel),
    .clr_ovf(clr_ovf),
    .C_out(C_out),
    .zf(zf),
    .nf(nf),
    .cf(cf),
    .vf(vf),
    .ovf_sticky(ovf_sticky),
    .res_vld(res_vld)
  );

  always #5 CLKb = ~CLKb;

  // Watchdog so a broken design can never hang the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int toSigned(input int u);
    return (u >= 128) ? u - 256 : u;
  endfunction

  // Behavioural ALU computed from the opcode table with integer arithmetic
  function automatic void refAlu(input int a, input int b, input int o,
                                 output int res, output bit [3:0] fl);
    int s;
    bit c;
    bit v;
    s = 0;
    c = 1'b0;
    v = 1'b0;
    res = 0;
    case (o)
      0: begin
        s = toSigned(a) + toSigned(b);
        c = (a + b) > 255;
        v = (s > 127) || (s < -128);
        res = (a + b) % 256;
      end
      1: begin
        s = toSigned(a) - toSigned(b);
        c = a < b;
        v = (s > 127) || (s < -128);
        res = (a - b + 256) % 256;
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = a;
      6: begin
        res = (a * 2) % 256;
        c = a >= 128;
      end
      default: res = 255 - a;
    endcase
`ifdef ALU_SAT_EN
    if (v) res = (s > 127) ? 127 : 128;
`endif
    fl = {res == 0, res >= 128, c, v};
  endfunction

  function automatic vec_t mk(input bit ea, input bit ealu, input bit ec, input logic [7:0] d,
                              input logic [2:0] o, input bit b, input bit clr,
                              input logic [7:0] xc, input bit xz, input bit xn, input bit xcy,
                              input bit xv, input bit xst, input bit xvld);
    vec_t t;
    t.en_a = ea;  t.en_alu = ealu;  t.en_c = ec;
    t.d = d;  t.o = o;  t.b = b;  t.clr = clr;
    t.exp_c = xc;  t.exp_z = xz;  t.exp_n = xn;  t.exp_cy = xcy;
    t.exp_v = xv;  t.exp_st = xst;  t.exp_vld = xvld;
    return t;
  endfunction

  task automatic modelReset();
    m_a = 0;  m_r = 0;  m_c = 0;
    m_rf = '0;  m_cf = '0;  m_st = 1'b0;  m_vld = 1'b0;
  endtask

  // Advance the reference by one edge using the inputs currently driven
  task automatic modelEdge();
    int nr;
    bit [3:0] nfl;
    bit nst;
    refAlu(m_a, bsel ? int'(din) : m_c, int'(op), nr, nfl);
    nst = (enC && m_rf[0]) ? 1'b1 : (clr_ovf ? 1'b0 : m_st);
    if (enC) begin
      m_c = m_r;
      m_cf = m_rf;
    end
    if (enALU) begin
      m_r = nr;
      m_rf = nfl;
    end
    if (enA) m_a = int'(din);
    m_vld = enC;
    m_st = nst;
  endtask

  // Drive one edge worth of inputs, then return just after the falling edge
  task automatic applyStimulus(input bit ea, input bit ealu, input bit ec, input logic [7:0] d,
                               input logic [2:0] o, input bit b, input bit clr);
    @(posedge CLKb);
    #1;
    enA = ea;  enALU = ealu;  enC = ec;
    din = d;  op = o;  bsel = b;  clr_ovf = clr;
    modelEdge();
    @(negedge CLKb);
    #1;
    enA = 1'b0;  enALU = 1'b0;  enC = 1'b0;  clr_ovf = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [7:0] xc,
                             input bit xz, input bit xn, input bit xcy, input bit xv,
                             input bit xst, input bit xvld);
    checks++;
    if ({C_out, zf, nf, cf, vf, ovf_sticky, res_vld} !== {xc, xz, xn, xcy, xv, xst, xvld}) begin
      errors++;
      $display("[TB] FAIL %s #%0d: got C=%02h z%b n%b c%b v%b st%b vld%b, expected C=%02h z%b n%b c%b v%b st%b vld%b",
               name, idx, C_out, zf, nf, cf, vf, ovf_sticky, res_vld,
               xc, xz, xn, xcy, xv, xst, xvld);
    end
  endtask

  task automatic checkModel(input string name, input int idx);
    checkOutput(name, idx, 8'(m_c), m_cf[3], m_cf[2], m_cf[1], m_cf[0], m_st, m_vld);
  endtask

  initial begin
    // Directed edges: ADD overflow, SUB borrow, SHL, AND, accumulation, sticky, all-strobes edge
    tbl.push_back(mk(1,0,0, 8'h70, 3'd0, 0, 0,  8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 8'h20, 3'd0, 1, 0,  8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  OV1_C, 0, OV1_N, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,0, 8'h00, 3'd0, 0, 0,  OV1_C, 0, OV1_N, 0, 1, 1, 0));
    tbl.push_back(mk(0,0,0, 8'h00, 3'd0, 0, 1,  OV1_C, 0, OV1_N, 0, 1, 0, 0));
    tbl.push_back(mk(1,0,0, 8'h05, 3'd0, 0, 0,  OV1_C, 0, OV1_N, 0, 1, 0, 0));
    tbl.push_back(mk(0,1,0, 8'h07, 3'd1, 1, 0,  OV1_C, 0, OV1_N, 0, 1, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'hFE, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1,0,0, 8'h81, 3'd0, 0, 0,  8'hFE, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 8'h00, 3'd6, 0, 0,  8'hFE, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'h02, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1,0,0, 8'hF0, 3'd0, 0, 0,  8'h02, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 8'h0F, 3'd2, 1, 0,  8'h02, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'h00, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1,0,0, 8'h01, 3'd0, 0, 0,  8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,1,0, 8'h01, 3'd0, 0, 0,  8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'h01, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1,1,0, 8'h01, 3'd0, 0, 0,  8'h01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'h02, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1,1,0, 8'h01, 3'd0, 0, 0,  8'h02, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'h03, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1,0,0, 8'h7F, 3'd0, 0, 0,  8'h03, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 8'h01, 3'd0, 1, 0,  8'h03, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 1,  OV2_C, 0, OV2_N, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,0, 8'h00, 3'd0, 0, 1,  OV2_C, 0, OV2_N, 0, 1, 0, 0));
    tbl.push_back(mk(1,0,0, 8'h03, 3'd0, 0, 0,  OV2_C, 0, OV2_N, 0, 1, 0, 0));
    tbl.push_back(mk(0,1,0, 8'h03, 3'd5, 1, 0,  OV2_C, 0, OV2_N, 0, 1, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'h03, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0,1,0, 8'h00, 3'd7, 0, 0,  8'h03, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,1,1, 8'h10, 3'd0, 0, 0,  8'hFC, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'h06, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0,1,0, 8'h00, 3'd7, 0, 0,  8'h06, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8'h00, 3'd0, 0, 0,  8'hEF, 0, 1, 0, 0, 0, 1));

    // Power-on reset: asynchronous assertion clears every output
    #2;
    RSTb = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_por", 0, 8'h00, 0, 0, 0, 0, 0, 0);
    @(posedge CLKb);
    #1;
    RSTb = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].en_a, tbl[i].en_alu, tbl[i].en_c, tbl[i].d, tbl[i].o, tbl[i].b, tbl[i].clr);
      checkOutput("vector", i, tbl[i].exp_c, tbl[i].exp_z, tbl[i].exp_n, tbl[i].exp_cy,
                  tbl[i].exp_v, tbl[i].exp_st, tbl[i].exp_vld);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));
      checkModel("random", i);
    end

    // Mid-operation reset: build up nonzero state, then pulse RSTb between edges
    applyStimulus(1, 0, 0, 8'h55, 3'd0, 0, 0);
    applyStimulus(0, 1, 0, 8'h33, 3'd3, 1, 0);
    applyStimulus(0, 0, 1, 8'h00, 3'd0, 0, 0);
    checkModel("pre_reset", 0);
    @(posedge CLKb);
    #2;
    RSTb = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_mid", 0, 8'h00, 0, 0, 0, 0, 0, 0);
    #1;
    RSTb = 1'b1;

    // After release nothing reaches C until the first commit
    applyStimulus(1, 1, 0, 8'h22, 3'd0, 1, 0);
    checkOutput("post_reset_hold", 0, 8'h00, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h11, 3'd0, 1, 0);
    checkOutput("post_reset_hold", 1, 8'h00, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 3'd0, 0, 0);
    checkOutput("post_reset_commit", 0, 8'h33, 0, 0, 0, 0, 0, 1);
    checkModel("post_reset_model", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Two-stage accumulator datapath that sits directly downstream of the two-state sequencing controller and consumes its `enA`, `enALU` and `enC` strobes. It does three things, each gated by one strobe:
- latches an input operand into register A;
- computes an ALU result and flags into an internal result register R;
- commits R and its flags to the visible accumulator C.

C feeds back as an ALU operand, so alternating controller states perform running accumulation.

## Interface
Parameters:
- WIDTH, 8, datapath width in bits (≥ 2)

Ports:
- CLKb  in  1  clock; every register updates on the falling edge, the same edge as the controller
- RSTb  in  1  reset, asynchronous and active-low
- enA  in  1  load `din` into A on this edge
- enALU  in  1  load ALU result and flags into R on this edge
- enC  in  1  commit R and its flags to C and the flag outputs on this edge
- din  in  WIDTH  external operand
- op  in  3  ALU opcode, sampled on enALU edges
- bsel  in  1  ALU B operand: 0 = C (accumulate), 1 = din
- clr_ovf  in  1  clear the sticky overflow flag
- C_out  out  WIDTH  accumulator C
- zf, nf, cf, vf  out  1 each  zero, negative, carry/borrow, signed overflow of the committed result
- ovf_sticky  out  1  set by any committed overflow
- res_vld  out  1  one-cycle pulse on the edge after each commit

## Operation
- Registers: A, R, R-flags, C, committed flags, ovf_sticky, res_vld.
- ALU is combinational on A (registered) and B (C or `din`, selected by `bsel`).
- Opcode set; arithmetic is unsigned modulo 2^WIDTH:

  | op | Name | Result | cf | vf |
  |---|---|---|---|---|
  | 000 | ADD | A+B | carry-out | signed overflow |
  | 001 | SUB | A−B | borrow (A<B unsigned) | signed overflow |
  | 010 | AND | A&B | 0 | 0 |
  | 011 | OR | A\|B | 0 | 0 |
  | 100 | XOR | A^B | 0 | 0 |
  | 101 | PASS | A | 0 | 0 |
  | 110 | SHL | A<<1, LSB=0 | old MSB | 0 |
  | 111 | NOT | ~A | 0 | 0 |

- zf = (result == 0); nf = result MSB. Both are computed on the final (post-saturation) value.
- Strobes are independent. Any combination, including all three in one edge, is legal.
- On an edge with enALU and enA together, R uses the old A.
- On an edge with enALU and enC together, C receives the old R and R takes the new value.
- With `bsel`=0, the ALU sees the C value from before that edge.
- ovf_sticky is set when enC=1 and the R vf=1. Otherwise it is cleared when clr_ovf=1. If both happen on the same edge, set wins.
- res_vld equals the enC value registered on that edge, so it is high for the cycle following each commit.

## Timing
- Reset (RSTb=0): A, R, R-flags, C_out, zf, nf, cf, vf, ovf_sticky and res_vld all go to 0 immediately, independent of CLKb.
- Reset is released synchronously to the next falling edge: the first update occurs on the first falling edge with RSTb=1.
- Reset mid-operation discards any in-flight A and R contents. There is no partial commit.
- Latency under the controller's alternating S0 (enA, enALU) / S1 (enC) schedule:
  - `din` captured into A at edge n
  - result in R at edge n+2 (the next S0)
  - visible on C_out at edge n+3
  - res_vld high during the cycle after edge n+3
- Throughput: one result per two clocks.
- Outputs are registered and never depend combinationally on inputs.

## Configuration
- `ALU_SAT_EN`
  - Defined: ADD and SUB results saturate on signed overflow. Positive overflow gives 2^(WIDTH−1)−1; negative overflow gives −2^(WIDTH−1). vf and cf still report the raw overflow and carry. zf and nf follow the saturated value.
  - Undefined: results wrap modulo 2^WIDTH. No saturation logic is present.

## Test plan
All scenarios use WIDTH=8.
- Reset: drive traffic, then pulse RSTb low between edges → every output is 0 before the next edge. After release, C_out stays 0 until the first enC.
- ADD overflow: A=0x70; enALU with bsel=1, din=0x20, op=000; then enC.
  - Without `ALU_SAT_EN`: C_out=0x90, vf=1, nf=1, cf=0, ovf_sticky=1, res_vld pulses once.
  - With `ALU_SAT_EN`: C_out=0x7F, vf=1, nf=0.
- SUB borrow: A=0x05; enALU with bsel=1, din=0x07, op=001; then enC → C_out=0xFE, cf=1, nf=1, vf=0, zf=0.
- Accumulate under controller alternation: A=0x01, bsel=0, op=ADD, held over three S0/S1 pairs → C_out steps 0x01, 0x02, 0x03, with one res_vld pulse per step.
- SHL and AND:
  - A=0x81, op=110 → C_out=0x02, cf=1.
  - A=0xF0, din=0x0F, bsel=1, op=010 → C_out=0x00, zf=1.
- Sticky flag:
  - clr_ovf on the same edge as an overflow commit → ovf_sticky=1.
  - clr_ovf on a later edge with no overflow → ovf_sticky=0.
  - Also cover enA, enALU and enC asserted on one edge → C takes the old R, R takes f(old A, old C).
